spi_master_ctrl: RTL and testbench

- Single-clock SPI master that turns host command requests into 10-bit SPI frames for the SPI slave/RAM wrapper.
- Drives SS_n and MOSI into the wrapper and samples its MISO.
- Sits directly upstream of the wrapper; the host side uses a valid/ready command port and a response port.
- Shifts one bit per clk cycle, synchronous to the slave clock.

---
 rtl/spi_master_ctrl.sv | 142 ++++++++++++++
 tb/tb_spi_master_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI master: turns host valid/ready commands into 10-bit {op, byte} frames, MSB first,
// and for rd_data commands collects the 8-bit reply from MISO after a turnaround.
module spi_master_ctrl #(
    parameter int unsigned RD_WAIT  = 2,
    parameter int unsigned IDLE_GAP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       done,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        StIdle,
        StChk,
        StShift,
        StWait,
        StRecv,
        StGap
    } state_e;

    localparam logic [3:0] WaitLast = 4'(RD_WAIT - 1);
    localparam logic [3:0] GapLast  = 4'(IDLE_GAP - 1);
    localparam logic [3:0] BitLast  = 4'd9;

    state_e     state_q;
    logic [9:0] frame_q;
    logic       is_read_q;
    logic [3:0] bit_cnt_q;
    logic [3:0] wait_cnt_q;
    logic [3:0] gap_cnt_q;
    logic [2:0] recv_cnt_q;
    logic [6:0] rx_q;

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            frame_q    <= '0;
            is_read_q  <= 1'b0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            gap_cnt_q  <= '0;
            recv_cnt_q <= '0;
            rx_q       <= '0;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            done       <= 1'b0;
            SS_n       <= 1'b1;
            MOSI       <= 1'b0;
        end else begin
            done      <= 1'b0;
            rsp_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        frame_q   <= {cmd_op, cmd_data};
                        is_read_q <= (cmd_op == 2'b11);
                        cmd_ready <= 1'b0;
                        SS_n      <= 1'b0;
                        MOSI      <= cmd_op[1];
                        state_q   <= StChk;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                StChk: begin
                    // The MSB is presented again for the first shift cycle.
                    MOSI      <= frame_q[9];
                    bit_cnt_q <= '0;
                    state_q   <= StShift;
                end
                StShift: begin
                    if (bit_cnt_q == BitLast) begin
                        MOSI <= 1'b0;
                        if (is_read_q) begin
                            wait_cnt_q <= '0;
                            recv_cnt_q <= '0;
                            state_q    <= (RD_WAIT == 0) ? StRecv : StWait;
                        end else begin
                            SS_n      <= 1'b1;
                            done      <= 1'b1;
                            gap_cnt_q <= '0;
                            state_q   <= StGap;
                        end
                    end else begin
                        // After i shifts, bit 8 holds original bit 8-i.
                        MOSI      <= frame_q[8];
                        frame_q   <= {frame_q[8:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                end
                StWait: begin
                    if (wait_cnt_q == WaitLast) begin
                        recv_cnt_q <= '0;
                        state_q    <= StRecv;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
                end
                StRecv: begin
                    rx_q <= {rx_q[5:0], MISO};
                    if (recv_cnt_q == 3'd7) begin
                        rsp_data  <= {rx_q, MISO};
                        rsp_valid <= 1'b1;
                        done      <= 1'b1;
                        SS_n      <= 1'b1;
                        gap_cnt_q <= '0;
                        state_q   <= StGap;
                    end else begin
                        recv_cnt_q <= recv_cnt_q + 3'd1;
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GapLast) begin
                        cmd_ready <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end
                default: begin
                    SS_n    <= 1'b1;
                    MOSI    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: frame timing, reads via a MISO slave model, busy
// rejection and reset during a read. Inputs driven and outputs sampled on the falling edge.
module tb_spi_master_ctrl;

    localparam int RdWait  = 2;
    localparam int IdleGap = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       done;
    logic       busy;
    logic       SS_n;
    logic       MOSI;
    logic       MISO = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] miso_byte = 8'h00;
    int         ss_cyc    = 0;

    spi_master_ctrl #(
        .RD_WAIT (RdWait),
        .IDLE_GAP(IdleGap)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .done     (done),
        .busy     (busy),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    always #5 clk = ~clk;

    // Slave model: cycle k of a frame (CHK = 1) drives reply bit 7-(k-12-RdWait) in RECV,
    // random noise everywhere else.
    always @(negedge clk) begin
        if (SS_n !== 1'b0) ss_cyc = 0;
        else ss_cyc = ss_cyc + 1;
        if (ss_cyc >= 12 + RdWait && ss_cyc < 20 + RdWait)
            MISO = miso_byte[3'(19 + RdWait - ss_cyc)];
        else
            MISO = 1'($urandom);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] data);
        for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) tick();
        check_eq("ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
    endtask

    // Called in cycle T (accept at its closing edge); returns in cycle T+11.
    // cmd_valid stays high through cycle T+hold with the substitute op/data.
    task automatic check_frame(input logic [9:0] f, input int hold,
                               input logic [1:0] nop, input logic [7:0] ndata);
        tick();
        check_eq("chk_ss", SS_n, 0);
        check_eq("chk_mosi", MOSI, f[9]);
        check_eq("chk_ready", cmd_ready, 0);
        check_eq("chk_busy", busy, 1);
        cmd_valid = (hold > 0);
        cmd_op    = nop;
        cmd_data  = ndata;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("shift_ss", SS_n, 0);
            check_eq("shift_mosi", MOSI, f[9-i]);
            check_eq("shift_ready", cmd_ready, 0);
            check_eq("shift_rsp", rsp_valid, 0);
            if (i + 2 > hold) cmd_valid = 1'b0;
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        tick();
        tick();
        check_eq("rst_ss", SS_n, 1);
        check_eq("rst_mosi", MOSI, 0);
        check_eq("rst_ready", cmd_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_rspv", rsp_valid, 0);
        check_eq("rst_rspd", rsp_data, 8'h00);
        rst = 1'b0;
        tick();
        check_eq("rst_ready_up", cmd_ready, 1);

        // wr_addr 0x3C; payload change after acceptance must not matter
        issue(2'b00, 8'h3C);
        check_frame(10'b00_0011_1100, 0, 2'b11, 8'hFF);
        tick();
        check_eq("wa_done", done, 1);
        check_eq("wa_ss_gap", SS_n, 1);
        check_eq("wa_mosi_gap", MOSI, 0);
        check_eq("wa_ready_gap", cmd_ready, 0);
        tick();
        check_eq("wa_ready", cmd_ready, 1);
        check_eq("wa_busy", busy, 0);
        check_eq("wa_done_off", done, 0);

        // wr_data 0xA5, then rd_addr 0x3C with cmd_valid held across the gap
        issue(2'b01, 8'hA5);
        check_frame(10'b01_1010_0101, 100, 2'b10, 8'h3C);
        tick();
        check_eq("wd_done", done, 1);
        check_eq("wd_ss_gap", SS_n, 1);
        tick();
        check_eq("wd_ss_idle", SS_n, 1);
        check_eq("wd_ready", cmd_ready, 1);
        check_frame(10'b10_0011_1100, 0, 2'b00, 8'h00);
        tick();
        check_eq("ra_done", done, 1);
        check_eq("ra_rspv", rsp_valid, 0);
        tick();
        check_eq("ra_ready", cmd_ready, 1);

        // rd_data returning 0x5A
        miso_byte = 8'h5A;
        issue(2'b11, 8'h00);
        check_frame(10'b11_0000_0000, 0, 2'b00, 8'h00);
        for (int k = 12; k < 22; k++) begin
            tick();
            check_eq("rd_ss_low", SS_n, 0);
            check_eq("rd_mosi0", MOSI, 0);
            check_eq("rd_rspv_early", rsp_valid, 0);
            check_eq("rd_done_early", done, 0);
        end
        tick();
        check_eq("rd_rspv", rsp_valid, 1);
        check_eq("rd_rspd", rsp_data, 8'h5A);
        check_eq("rd_ss_high", SS_n, 1);
        check_eq("rd_done", done, 1);
        tick();
        check_eq("rd_rspv_off", rsp_valid, 0);
        check_eq("rd_rspd_hold", rsp_data, 8'h5A);
        check_eq("rd_ready", cmd_ready, 1);

        // busy rejection: 00/0xFF offered for 3 cycles during a wr_addr 0x81 frame
        issue(2'b00, 8'h81);
        check_frame(10'b00_1000_0001, 3, 2'b00, 8'hFF);
        tick();
        check_eq("bz_done", done, 1);
        tick();
        check_eq("bz_ready", cmd_ready, 1);
        tick();
        check_eq("bz_no_frame_ss", SS_n, 1);
        check_eq("bz_no_frame_busy", busy, 0);

        // reset asserted in the 4th RECV cycle (T+17)
        miso_byte = 8'hC3;
        issue(2'b11, 8'h00);
        check_frame(10'b11_0000_0000, 0, 2'b00, 8'h00);
        for (int k = 12; k < 18; k++) tick();
        check_eq("mr_ss_before", SS_n, 0);
        rst = 1'b1;
        tick();
        check_eq("mr_ss", SS_n, 1);
        check_eq("mr_done", done, 0);
        check_eq("mr_rspv", rsp_valid, 0);
        check_eq("mr_rspd", rsp_data, 8'h00);
        check_eq("mr_ready_rst", cmd_ready, 0);
        rst = 1'b0;
        tick();
        check_eq("mr_ready", cmd_ready, 1);
        check_eq("mr_done_after", done, 0);
        check_eq("mr_rspv_after", rsp_valid, 0);
        tick();
        check_eq("mr_rspv_later", rsp_valid, 0);
        check_eq("mr_ss_idle", SS_n, 1);

        // back-to-back reads 0x11 then 0xEE
        miso_byte = 8'h11;
        issue(2'b11, 8'h00);
        check_frame(10'b11_0000_0000, 100, 2'b11, 8'h00);
        for (int k = 12; k < 22; k++) begin
            tick();
            check_eq("bb1_rspv_early", rsp_valid, 0);
        end
        tick();
        check_eq("bb1_rspv", rsp_valid, 1);
        check_eq("bb1_rspd", rsp_data, 8'h11);
        miso_byte = 8'hEE;
        tick();
        check_eq("bb1_rspv_off", rsp_valid, 0);
        check_eq("bb1_ready", cmd_ready, 1);
        check_frame(10'b11_0000_0000, 0, 2'b00, 8'h00);
        for (int k = 12; k < 22; k++) begin
            tick();
            check_eq("bb2_rspv_early", rsp_valid, 0);
            check_eq("bb2_rspd_stable", rsp_data, 8'h11);
        end
        tick();
        check_eq("bb2_rspv", rsp_valid, 1);
        check_eq("bb2_rspd", rsp_data, 8'hEE);
        tick();
        check_eq("bb2_rspv_off", rsp_valid, 0);
        check_eq("bb2_rspd_hold", rsp_data, 8'hEE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
